// File: rtl/trig_coinc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// trig_coinc_ctrl_pkg
//   Shared definitions for the coincidence trigger controller:
//   - FSM state encodings as reported on TRG_STATE
//   - bit positions inside TRG_SOURCE
//   - saturating 32-bit increment used by the statistics counters
// ----------------------------------------------------------------------------
package trig_coinc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FIRE      = 3'd1;
    localparam logic [2:0] ST_HOLDOFF   = 3'd2;
    localparam logic [2:0] ST_VETO_WAIT = 3'd3;
    localparam logic [2:0] ST_VETO_CNT  = 3'd4;

    localparam int unsigned SRC_HW_BIT   = 0;
    localparam int unsigned SRC_SOFT_BIT = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trig_coinc_ctrl_ack_stretch.sv
// ----------------------------------------------------------------------------
// trig_ack_stretch
//   One SCROD channel's coincidence-window stretcher. A rising edge on the
//   registered, masked ACK keeps the channel counted for COINC_WIN cycles.
// Ports
//   CLK_42MHZ  in   system clock
//   RESET      in   async, active-high reset
//   ack_r      in   registered ACK & TRG_MASK for this channel
//   active     out  channel currently contributes to the coincidence count
// ----------------------------------------------------------------------------
module trig_ack_stretch #(
    parameter int unsigned COINC_WIN = 2
) (
    input  logic CLK_42MHZ,
    input  logic RESET,
    input  logic ack_r,
    output logic active
);

    // ack_r itself covers the first cycle of the window, so the counter
    // only has to carry the remaining COINC_WIN-1 cycles.
    localparam int unsigned LOAD = (COINC_WIN == 0) ? 0 : COINC_WIN - 1;
    localparam int unsigned W    = (LOAD <= 1) ? 1 : $clog2(LOAD + 1);

    logic         ack_q;
    logic [W-1:0] win_cnt;

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) begin
            ack_q   <= 1'b0;
            win_cnt <= '0;
        end else begin
            ack_q <= ack_r;
            if (ack_r && !ack_q)
                win_cnt <= W'(LOAD);
            else if (win_cnt != '0)
                win_cnt <= win_cnt - 1'b1;
        end
    end

    assign active = ack_r | (win_cnt != '0);

endmodule

// File: rtl/trig_coinc_ctrl.sv
// ----------------------------------------------------------------------------
// trig_coinc_ctrl
//   Coincidence trigger generator for N_SCRODS SCROD links. Masked ACKs are
//   stretched and counted; a hardware trigger fires when the count reaches
//   MIN_SCRODS_REQUIRED. A synchronised soft trigger can also fire. TRG is
//   fanned out with holdoff and DAQ flow-control veto.
// Ports
//   CLK_42MHZ           in   system clock
//   RESET               in   async, active-high reset
//   ACK                 in   per-SCROD trigger request
//   TRG_MASK            in   1 = channel participates in coincidence
//   MIN_SCRODS_REQUIRED in   coincidence threshold, 0 disables hw trigger
//   TRG_SOFT            in   async soft trigger (rising edge)
//   TRG_FLOW_CTL_EN     in   1 = enter veto after each trigger
//   TRG_VETO_RESET      in   DAQ readout done, starts veto release countdown
//   VETO_HOLD_CYC       in   countdown length after veto reset
//   TRG                 out  trigger to SCRODs
//   TRG_NEEDS_VETO      out  trigger accepted, veto not yet released
//   TRG_STATISTICS      out  accepted-trigger count, saturating
//   TRG_LOST            out  triggers rejected while busy, saturating
//   TRG_SOURCE          out  {soft,hw} source of last accepted trigger
//   TRG_STATE           out  FSM state, debug
// ----------------------------------------------------------------------------
module trig_coinc_ctrl
    import trig_coinc_ctrl_pkg::*;
#(
    parameter int unsigned N_SCRODS      = 12,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned COINC_WIN     = 2,
    parameter int unsigned TRG_PULSE_LEN = 8,
    parameter int unsigned HOLDOFF_CYC   = 7,
    parameter int unsigned VETO_CNT_W    = 20,
    parameter int unsigned BROADCAST_ALL = 1
) (
    input  logic                  CLK_42MHZ,
    input  logic                  RESET,
    input  logic [N_SCRODS-1:0]   ACK,
    input  logic [N_SCRODS-1:0]   TRG_MASK,
    input  logic [CNT_W-1:0]      MIN_SCRODS_REQUIRED,
    input  logic                  TRG_SOFT,
    input  logic                  TRG_FLOW_CTL_EN,
    input  logic                  TRG_VETO_RESET,
    input  logic [VETO_CNT_W-1:0] VETO_HOLD_CYC,
    output logic [N_SCRODS-1:0]   TRG,
    output logic                  TRG_NEEDS_VETO,
    output logic [31:0]           TRG_STATISTICS,
    output logic [31:0]           TRG_LOST,
    output logic [1:0]            TRG_SOURCE,
    output logic [2:0]            TRG_STATE
);

    localparam int unsigned CYC_MAX    = (TRG_PULSE_LEN > HOLDOFF_CYC) ? TRG_PULSE_LEN : HOLDOFF_CYC;
    localparam int unsigned CYC_W      = (CYC_MAX <= 1) ? 1 : $clog2(CYC_MAX + 1);
    localparam int unsigned PULSE_LAST = (TRG_PULSE_LEN == 0) ? 0 : TRG_PULSE_LEN - 1;
    localparam int unsigned HOLD_LAST  = (HOLDOFF_CYC == 0) ? 0 : HOLDOFF_CYC - 1;

    // ------------------------------------------------------------------
    // Hardware coincidence path
    // ------------------------------------------------------------------
    logic [N_SCRODS-1:0] ack_r;
    logic [N_SCRODS-1:0] active;
    logic [CNT_W-1:0]    pop;
    logic [CNT_W-1:0]    cnt_r;
    logic                hw_hit;

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) ack_r <= '0;
        else       ack_r <= ACK & TRG_MASK;
    end

    for (genvar g = 0; g < N_SCRODS; g++) begin : g_stretch
        trig_ack_stretch #(
            .COINC_WIN(COINC_WIN)
        ) u_stretch (
            .CLK_42MHZ(CLK_42MHZ),
            .RESET    (RESET),
            .ack_r    (ack_r[g]),
            .active   (active[g])
        );
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_SCRODS; i++)
            pop = pop + CNT_W'(active[i]);
    end

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) cnt_r <= '0;
        else       cnt_r <= pop;
    end

    assign hw_hit = (MIN_SCRODS_REQUIRED != '0) && (cnt_r >= MIN_SCRODS_REQUIRED);

    // ------------------------------------------------------------------
    // Soft trigger: 2-FF synchroniser, then registered rise detect
    // ------------------------------------------------------------------
    logic soft_s1, soft_s2, soft_s3, soft_hit;

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) begin
            soft_s1  <= 1'b0;
            soft_s2  <= 1'b0;
            soft_s3  <= 1'b0;
            soft_hit <= 1'b0;
        end else begin
            soft_s1  <= TRG_SOFT;
            soft_s2  <= soft_s1;
            soft_s3  <= soft_s2;
            soft_hit <= soft_s2 & ~soft_s3;
        end
    end

    // ------------------------------------------------------------------
    // Trigger FSM and counters
    // ------------------------------------------------------------------
    logic                  hit, hit_q, hit_rise;
    logic [2:0]            state;
    logic [CYC_W-1:0]      cyc;
    logic [VETO_CNT_W-1:0] veto_cnt;
    logic                  needs_veto;
    logic                  pending_rel;
    logic [N_SCRODS-1:0]   trg_r;
    logic [N_SCRODS-1:0]   trg_val;
    logic [31:0]           stat_r;
    logic [31:0]           lost_r;
    logic [1:0]            src_r;

    assign hit      = hw_hit | soft_hit;
    assign hit_rise = hit & ~hit_q;
    assign trg_val  = (BROADCAST_ALL != 0) ? {N_SCRODS{1'b1}} : TRG_MASK;

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) hit_q <= 1'b0;
        else       hit_q <= hit;
    end

    always_ff @(posedge CLK_42MHZ or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cyc         <= '0;
            veto_cnt    <= '0;
            needs_veto  <= 1'b0;
            pending_rel <= 1'b0;
            trg_r       <= '0;
            stat_r      <= '0;
            lost_r      <= '0;
            src_r       <= '0;
        end else begin
            if (hit_rise && (state != ST_IDLE))
                lost_r <= sat_inc(lost_r);

            case (state)
                ST_IDLE: begin
                    pending_rel <= 1'b0;
                    if (hit) begin
                        state                <= ST_FIRE;
                        cyc                  <= '0;
                        trg_r                <= trg_val;
                        stat_r               <= sat_inc(stat_r);
                        src_r[SRC_SOFT_BIT]  <= soft_hit;
                        src_r[SRC_HW_BIT]    <= hw_hit;
                        if (TRG_FLOW_CTL_EN)
                            needs_veto <= 1'b1;
                    end
                end

                ST_FIRE: begin
                    if (TRG_VETO_RESET)
                        pending_rel <= 1'b1;
                    if (cyc == CYC_W'(PULSE_LAST)) begin
                        trg_r <= '0;
                        cyc   <= '0;
                        if (HOLDOFF_CYC != 0)
                            state <= ST_HOLDOFF;
                        else
                            state <= needs_veto ? ST_VETO_WAIT : ST_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                ST_HOLDOFF: begin
                    if (TRG_VETO_RESET)
                        pending_rel <= 1'b1;
                    if (cyc == CYC_W'(HOLD_LAST)) begin
                        cyc   <= '0;
                        state <= needs_veto ? ST_VETO_WAIT : ST_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                ST_VETO_WAIT: begin
                    if (pending_rel || TRG_VETO_RESET || !TRG_FLOW_CTL_EN) begin
                        state       <= ST_VETO_CNT;
                        veto_cnt    <= VETO_HOLD_CYC;
                        pending_rel <= 1'b0;
                    end
                end

                ST_VETO_CNT: begin
                    // Release on the edge that sees 1 (or 0) so that a load of
                    // N keeps the veto exactly N cycles after entering here.
                    if (TRG_VETO_RESET) begin
                        veto_cnt <= VETO_HOLD_CYC;
                    end else if (veto_cnt <= VETO_CNT_W'(1)) begin
                        veto_cnt   <= '0;
                        needs_veto <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        veto_cnt <= veto_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign TRG            = trg_r;
    assign TRG_NEEDS_VETO = needs_veto;
    assign TRG_STATISTICS = stat_r;
    assign TRG_LOST       = lost_r;
    assign TRG_SOURCE     = src_r;
    assign TRG_STATE      = state;

endmodule

// File: tb/tb_trig_coinc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trig_coinc_ctrl
//   Directed self-checking bench for trig_coinc_ctrl with default parameters
//   (12 channels, COINC_WIN=2, 8-cycle TRG pulse, 7-cycle holdoff).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_trig_coinc_ctrl;

    logic        CLK_42MHZ = 1'b0;
    logic        RESET;
    logic [11:0] ACK;
    logic [11:0] TRG_MASK;
    logic [3:0]  MIN_SCRODS_REQUIRED;
    logic        TRG_SOFT;
    logic        TRG_FLOW_CTL_EN;
    logic        TRG_VETO_RESET;
    logic [19:0] VETO_HOLD_CYC;
    logic [11:0] TRG;
    logic        TRG_NEEDS_VETO;
    logic [31:0] TRG_STATISTICS;
    logic [31:0] TRG_LOST;
    logic [1:0]  TRG_SOURCE;
    logic [2:0]  TRG_STATE;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_stat = 32'd0;
    logic [31:0] exp_lost = 32'd0;

    always #5 CLK_42MHZ = ~CLK_42MHZ;

    trig_coinc_ctrl #(
        .N_SCRODS     (12),
        .CNT_W        (4),
        .COINC_WIN    (2),
        .TRG_PULSE_LEN(8),
        .HOLDOFF_CYC  (7),
        .VETO_CNT_W   (20),
        .BROADCAST_ALL(1)
    ) dut (
        .CLK_42MHZ          (CLK_42MHZ),
        .RESET              (RESET),
        .ACK                (ACK),
        .TRG_MASK           (TRG_MASK),
        .MIN_SCRODS_REQUIRED(MIN_SCRODS_REQUIRED),
        .TRG_SOFT           (TRG_SOFT),
        .TRG_FLOW_CTL_EN    (TRG_FLOW_CTL_EN),
        .TRG_VETO_RESET     (TRG_VETO_RESET),
        .VETO_HOLD_CYC      (VETO_HOLD_CYC),
        .TRG                (TRG),
        .TRG_NEEDS_VETO     (TRG_NEEDS_VETO),
        .TRG_STATISTICS     (TRG_STATISTICS),
        .TRG_LOST           (TRG_LOST),
        .TRG_SOURCE         (TRG_SOURCE),
        .TRG_STATE          (TRG_STATE)
    );

    // Stimulus helpers (no checking inside).
    task automatic pulse_ack(input logic [11:0] v);
        @(negedge CLK_42MHZ);
        ACK = v;
        @(negedge CLK_42MHZ);
        ACK = '0;
    endtask

    task automatic pulse_veto_reset();
        TRG_VETO_RESET = 1'b1;
        @(negedge CLK_42MHZ);
        TRG_VETO_RESET = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (TRG_STATE == st) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_42MHZ);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ACK = '0;
        TRG_MASK = 12'hFFF;
        MIN_SCRODS_REQUIRED = 4'd3;
        TRG_SOFT = 1'b0;
        TRG_FLOW_CTL_EN = 1'b0;
        TRG_VETO_RESET = 1'b0;
        VETO_HOLD_CYC = 20'd5;
        repeat (3) @(negedge CLK_42MHZ);
        RESET = 1'b0;
        @(negedge CLK_42MHZ);
        checks++; if (TRG !== 12'h000) begin errors++; $display("FAIL reset_trg: got %h expected %h", TRG, 12'h000); end
        checks++; if (TRG_NEEDS_VETO !== 1'b0) begin errors++; $display("FAIL reset_veto: got %b expected 0", TRG_NEEDS_VETO); end
        checks++; if (TRG_STATISTICS !== 32'd0) begin errors++; $display("FAIL reset_stat: got %h expected 0", TRG_STATISTICS); end
        checks++; if (TRG_LOST !== 32'd0) begin errors++; $display("FAIL reset_lost: got %h expected 0", TRG_LOST); end
        checks++; if (TRG_SOURCE !== 2'b00) begin errors++; $display("FAIL reset_source: got %b expected 00", TRG_SOURCE); end
        checks++; if (TRG_STATE !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", TRG_STATE); end
    endtask

    task automatic test_hw_coinc();
        int unsigned hi;
        bit ok;
        MIN_SCRODS_REQUIRED = 4'd3;
        pulse_ack(12'h211);                    // channels 0,4,9 sampled at edge t
        @(negedge CLK_42MHZ);                  // after t+1
        checks++; if (TRG !== 12'h000) begin errors++; $display("FAIL hw_latency_early: got %h expected 000", TRG); end
        @(negedge CLK_42MHZ);                  // after t+2
        checks++; if (TRG !== 12'hFFF) begin errors++; $display("FAIL hw_latency: got %h expected FFF", TRG); end
        hi = 0;
        repeat (7) begin
            @(negedge CLK_42MHZ);
            if (TRG === 12'hFFF) hi++;
        end
        checks++; if (hi != 7) begin errors++; $display("FAIL hw_pulse_len: got %0d more high cycles expected 7", hi); end
        @(negedge CLK_42MHZ);
        checks++; if (TRG !== 12'h000) begin errors++; $display("FAIL hw_pulse_end: got %h expected 000", TRG); end
        exp_stat = exp_stat + 1;
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL hw_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
        checks++; if (TRG_SOURCE !== 2'b01) begin errors++; $display("FAIL hw_source: got %b expected 01", TRG_SOURCE); end
        wait_state(3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hw_idle_timeout: got state %0d expected 0", TRG_STATE); end
    endtask

    task automatic test_window();
        bit seen;
        bit ok;
        MIN_SCRODS_REQUIRED = 4'd2;
        // ACK[1] at t, ACK[2] at t+1: windows overlap
        @(negedge CLK_42MHZ); ACK = 12'h002;
        @(negedge CLK_42MHZ); ACK = 12'h004;
        @(negedge CLK_42MHZ); ACK = 12'h000;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK_42MHZ);
            if (TRG !== 12'h000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL window_overlap: got trg_seen=%b expected 1", seen); end
        exp_stat = exp_stat + 1;
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL window_overlap_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
        wait_state(3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL window_idle_timeout: got state %0d expected 0", TRG_STATE); end
        // ACK[1] at t, ACK[2] at t+3: windows do not overlap
        @(negedge CLK_42MHZ); ACK = 12'h002;
        @(negedge CLK_42MHZ); ACK = 12'h000;
        @(negedge CLK_42MHZ);
        @(negedge CLK_42MHZ); ACK = 12'h004;
        @(negedge CLK_42MHZ); ACK = 12'h000;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK_42MHZ);
            if (TRG !== 12'h000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL window_gap: got trg_seen=%b expected 0", seen); end
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL window_gap_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
    endtask

    task automatic test_veto();
        int unsigned n;
        bit ok;
        MIN_SCRODS_REQUIRED = 4'd3;
        TRG_FLOW_CTL_EN = 1'b1;
        VETO_HOLD_CYC = 20'd5;
        pulse_ack(12'h211);
        wait_state(3'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL veto_fire_timeout: got state %0d expected 1", TRG_STATE); end
        exp_stat = exp_stat + 1;
        checks++; if (TRG_NEEDS_VETO !== 1'b1) begin errors++; $display("FAIL veto_set: got %b expected 1", TRG_NEEDS_VETO); end
        pulse_veto_reset();                    // readout done early, during FIRE
        wait_state(3'd4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL veto_cnt_timeout: got state %0d expected 4", TRG_STATE); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_42MHZ);
            n++;
            if (TRG_NEEDS_VETO === 1'b0) break;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL veto_release_time: got %0d cycles expected 5", n); end
        checks++; if (TRG_STATE !== 3'd0) begin errors++; $display("FAIL veto_release_state: got %0d expected 0", TRG_STATE); end
        // second trigger, then a hit while waiting for readout
        pulse_ack(12'h211);
        exp_stat = exp_stat + 1;
        wait_state(3'd3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL veto_wait_timeout: got state %0d expected 3", TRG_STATE); end
        pulse_ack(12'h211);
        repeat (4) @(negedge CLK_42MHZ);
        exp_lost = exp_lost + 1;
        checks++; if (TRG_LOST !== exp_lost) begin errors++; $display("FAIL veto_lost: got %0d expected %0d", TRG_LOST, exp_lost); end
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL veto_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
        checks++; if (TRG !== 12'h000) begin errors++; $display("FAIL veto_trg_blocked: got %h expected 000", TRG); end
        checks++; if (TRG_STATE !== 3'd3) begin errors++; $display("FAIL veto_still_waiting: got %0d expected 3", TRG_STATE); end
        pulse_veto_reset();
        wait_state(3'd0, ok);
        checks++; if (!ok || TRG_NEEDS_VETO !== 1'b0) begin errors++; $display("FAIL veto_final_release: got state %0d veto %b expected 0 0", TRG_STATE, TRG_NEEDS_VETO); end
        TRG_FLOW_CTL_EN = 1'b0;
    endtask

    task automatic test_soft();
        int unsigned hi;
        bit seen;
        bit ok;
        MIN_SCRODS_REQUIRED = 4'd3;
        // soft only: sampled at t', TRG after t'+3
        @(negedge CLK_42MHZ); TRG_SOFT = 1'b1;
        @(negedge CLK_42MHZ); TRG_SOFT = 1'b0;  // after t'
        @(negedge CLK_42MHZ);
        @(negedge CLK_42MHZ);                   // after t'+2
        checks++; if (TRG !== 12'h000) begin errors++; $display("FAIL soft_latency_early: got %h expected 000", TRG); end
        @(negedge CLK_42MHZ);                   // after t'+3
        checks++; if (TRG !== 12'hFFF) begin errors++; $display("FAIL soft_latency: got %h expected FFF", TRG); end
        exp_stat = exp_stat + 1;
        checks++; if (TRG_SOURCE !== 2'b10) begin errors++; $display("FAIL soft_source: got %b expected 10", TRG_SOURCE); end
        wait_state(3'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL soft_idle_timeout: got state %0d expected 0", TRG_STATE); end
        // soft and hw hit land on the same cycle
        @(negedge CLK_42MHZ); TRG_SOFT = 1'b1;
        @(negedge CLK_42MHZ); ACK = 12'h211;
        @(negedge CLK_42MHZ); ACK = 12'h000; TRG_SOFT = 1'b0;
        hi = 0;
        repeat (30) begin
            @(negedge CLK_42MHZ);
            if (TRG !== 12'h000) hi++;
        end
        exp_stat = exp_stat + 1;
        checks++; if (hi != 8) begin errors++; $display("FAIL both_one_pulse: got %0d high cycles expected 8", hi); end
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL both_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
        checks++; if (TRG_SOURCE !== 2'b11) begin errors++; $display("FAIL both_source: got %b expected 11", TRG_SOURCE); end
        checks++; if (TRG_LOST !== exp_lost) begin errors++; $display("FAIL both_lost: got %0d expected %0d", TRG_LOST, exp_lost); end
        // threshold 0 disables the hardware trigger
        MIN_SCRODS_REQUIRED = 4'd0;
        @(negedge CLK_42MHZ); ACK = 12'hFFF;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK_42MHZ);
            if (TRG !== 12'h000) seen = 1'b1;
        end
        ACK = 12'h000;
        repeat (3) @(negedge CLK_42MHZ);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL thr0_no_trg: got trg_seen=%b expected 0", seen); end
        checks++; if (TRG_STATISTICS !== exp_stat) begin errors++; $display("FAIL thr0_stat: got %0d expected %0d", TRG_STATISTICS, exp_stat); end
        MIN_SCRODS_REQUIRED = 4'd3;
    endtask

    task automatic test_async_reset();
        bit ok;
        TRG_FLOW_CTL_EN = 1'b1;
        VETO_HOLD_CYC = 20'd1000;
        pulse_ack(12'h211);
        wait_state(3'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_fire_timeout: got state %0d expected 1", TRG_STATE); end
        #1 RESET = 1'b1;
        #1;
        checks++; if (TRG !== 12'h000 || TRG_NEEDS_VETO !== 1'b0) begin errors++; $display("FAIL rst_fire_outputs: got trg %h veto %b expected 000 0", TRG, TRG_NEEDS_VETO); end
        checks++; if (TRG_STATISTICS !== 32'd0 || TRG_LOST !== 32'd0) begin errors++; $display("FAIL rst_fire_counters: got stat %0d lost %0d expected 0 0", TRG_STATISTICS, TRG_LOST); end
        @(negedge CLK_42MHZ); RESET = 1'b0;
        exp_stat = 32'd0;
        exp_lost = 32'd0;
        pulse_ack(12'h211);
        wait_state(3'd3, ok);
        pulse_veto_reset();
        wait_state(3'd4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_vcnt_timeout: got state %0d expected 4", TRG_STATE); end
        #1 RESET = 1'b1;
        #1;
        checks++; if (TRG_NEEDS_VETO !== 1'b0 || TRG_STATE !== 3'd0) begin errors++; $display("FAIL rst_vcnt_outputs: got veto %b state %0d expected 0 0", TRG_NEEDS_VETO, TRG_STATE); end
        checks++; if (TRG_STATISTICS !== 32'd0) begin errors++; $display("FAIL rst_vcnt_stat: got %0d expected 0", TRG_STATISTICS); end
        @(negedge CLK_42MHZ); RESET = 1'b0;
        TRG_FLOW_CTL_EN = 1'b0;
        VETO_HOLD_CYC = 20'd5;
    endtask

    task automatic test_saturation();
        bit ok;
        @(negedge CLK_42MHZ);
        force dut.stat_r = 32'hFFFF_FFFE;
        #1 release dut.stat_r;
        @(negedge CLK_42MHZ);
        checks++; if (TRG_STATISTICS !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h expected FFFFFFFE", TRG_STATISTICS); end
        pulse_ack(12'h211);
        wait_state(3'd1, ok);
        wait_state(3'd0, ok);
        checks++; if (!ok || TRG_STATISTICS !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first: got %h expected FFFFFFFF", TRG_STATISTICS); end
        pulse_ack(12'h211);
        wait_state(3'd1, ok);
        wait_state(3'd0, ok);
        checks++; if (!ok || TRG_STATISTICS !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h expected FFFFFFFF", TRG_STATISTICS); end
    endtask

    initial begin
        test_reset();
        test_hw_coinc();
        test_window();
        test_veto();
        test_soft();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
